cache_lru_part_mt: RTL

//  Per-set true-LRU replacement engine for I/D caches with N hardware threads. Ages form a per-set permutation.

---
 rtl/cache_lru_part_mt.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/cache_lru_part_mt.sv
// Per-set true-LRU replacement engine with per-thread way partitioning.
// Ages are a per-set permutation; an init sweep reloads them after reset or flush.
module cache_lru_part_mt #(
    parameter int  NUM_SET        = 16,
    parameter int  WAYS_PER_SET   = 4,
    parameter int  NUM_THREADS    = 2,
    localparam int WAYS_PER_THR   = WAYS_PER_SET / NUM_THREADS,
    localparam int NUM_SET_W      = $clog2(NUM_SET),
    localparam int WAYS_PER_SET_W = $clog2(WAYS_PER_SET),
    localparam int THR_W          = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      mt_mode,  // 0: single-threaded, 1: partitioned
    input  logic                      flush_req,
    output logic                      ready,
    input  logic                      victim_req,
    input  logic [NUM_SET_W-1:0]      victim_set,
    input  logic [THR_W-1:0]          victim_thread,
    input  logic [WAYS_PER_SET-1:0]   victim_valid,
    output logic                      victim_vld,
    output logic [WAYS_PER_SET_W-1:0] victim_way,
    input  logic                      hit_req,
    input  logic [NUM_SET_W-1:0]      hit_set,
    input  logic [WAYS_PER_SET_W-1:0] hit_way,
    input  logic                      fill_req,
    input  logic [NUM_SET_W-1:0]      fill_set,
    input  logic [WAYS_PER_SET_W-1:0] fill_way
);

    typedef logic [WAYS_PER_SET_W-1:0] age_t;
    typedef age_t [WAYS_PER_SET-1:0]   set_age_t;
    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                      state_q, state_d;
    logic [NUM_SET_W-1:0]        sweep_ptr_q, sweep_ptr_d;
    logic                        ready_q, ready_d;
    logic                        victim_vld_q, victim_vld_d;
    logic [WAYS_PER_SET_W-1:0]   victim_way_q, victim_way_d;
    set_age_t                    age_q [NUM_SET];
    set_age_t                    age_d [NUM_SET];

    // Move way u to MRU; only ways younger than u age, so the permutation is preserved.
    function automatic set_age_t touch(input set_age_t ages, input age_t u);
        set_age_t r;
        r = ages;
        for (int w = 0; w < WAYS_PER_SET; w++) begin
            if (ages[w] < ages[u]) r[w] = ages[w] + age_t'(1);
        end
        r[u] = '0;
        return r;
    endfunction

    always_comb begin
        state_d     = state_q;
        sweep_ptr_d = sweep_ptr_q;
        ready_d     = ready_q;
        case (state_q)
            ST_INIT: begin
                if (flush_req) begin
                    sweep_ptr_d = '0;
                end else begin
                    sweep_ptr_d = sweep_ptr_q + 1'b1;
                    if (sweep_ptr_q == NUM_SET_W'(NUM_SET - 1)) begin
                        state_d = ST_RUN;
                        ready_d = 1'b1;
                    end
                end
            end
            default: begin
                if (flush_req) begin
                    state_d     = ST_INIT;
                    sweep_ptr_d = '0;
                    ready_d     = 1'b0;
                end
            end
        endcase
    end

    logic                      accept;
    logic                      elig;
    logic                      found_inv;
    logic                      have_max;
    logic [WAYS_PER_SET_W-1:0] inv_way;
    logic [WAYS_PER_SET_W-1:0] max_way;
    age_t                      best_age;

    assign accept = ready_q && victim_req;

    always_comb begin
        found_inv = 1'b0;
        have_max  = 1'b0;
        inv_way   = '0;
        max_way   = '0;
        best_age  = '0;
        elig      = 1'b0;
        for (int w = 0; w < WAYS_PER_SET; w++) begin
            elig = !mt_mode || ((w / WAYS_PER_THR) == int'(victim_thread));
            if (elig && !victim_valid[w] && !found_inv) begin
                found_inv = 1'b1;
                inv_way   = WAYS_PER_SET_W'(w);
            end
            if (elig && (!have_max || age_q[victim_set][w] > best_age)) begin
                have_max = 1'b1;
                best_age = age_q[victim_set][w];
                max_way  = WAYS_PER_SET_W'(w);
            end
        end
        victim_vld_d = accept;
        victim_way_d = victim_way_q;
        if (accept) victim_way_d = found_inv ? inv_way : max_way;
    end

    set_age_t tmp;

    // Hit is applied before fill so a same-set pair chains within one cycle.
    always_comb begin
        tmp = '0;
        for (int s = 0; s < NUM_SET; s++) begin
            tmp = age_q[s];
            if (ready_q && hit_req && hit_set == NUM_SET_W'(s)) tmp = touch(tmp, hit_way);
            if (ready_q && fill_req && fill_set == NUM_SET_W'(s)) tmp = touch(tmp, fill_way);
            if (state_q == ST_INIT && sweep_ptr_q == NUM_SET_W'(s)) begin
                for (int w = 0; w < WAYS_PER_SET; w++) tmp[w] = age_t'(WAYS_PER_SET - 1 - w);
            end
            age_d[s] = tmp;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_INIT;
            sweep_ptr_q  <= '0;
            ready_q      <= 1'b0;
            victim_vld_q <= 1'b0;
            victim_way_q <= '0;
        end else begin
            state_q      <= state_d;
            sweep_ptr_q  <= sweep_ptr_d;
            ready_q      <= ready_d;
            victim_vld_q <= victim_vld_d;
            victim_way_q <= victim_way_d;
        end
    end

    always_ff @(posedge clock) begin
        age_q <= age_d;
    end

    assign ready      = ready_q;
    assign victim_vld = victim_vld_q;
    assign victim_way = victim_way_q;

endmodule
